// File: rtl/serializer_pkg.sv
// Shared types and width constants for the serial link (serializer and deserializer).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serializer_pkg;

    // Default parallel word width; the deserializer uses the same constant.
    localparam int SER_W     = 16;
    localparam int SER_MOD_W = $clog2(SER_W);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage : serializer_pkg

// File: rtl/serializer.sv
// Parallel-to-serial shifter: sends the top L bits of a word, MSB first, one bit per cycle.
// Latency: first bit on ser_data_o one cycle after the accepting edge; L cycles per word.
// Backpressure: none on the input; requests arriving while busy_o=1 are dropped.
//
// Ports:
//   clk_i           clock, rising edge
//   srst_n_i        synchronous active-low reset
//   data_i          parallel word, bit W-1 sent first
//   data_mod_i      number of valid bits counted from bit W-1 (0 means W; 1 and 2 are rejected)
//   data_val_i      request strobe qualifying data_i / data_mod_i
//   ser_data_o      serial bit (0 whenever ser_data_val_o=0)
//   ser_data_val_o  serial bit valid
//   busy_o          word in flight (state==SEND)
module serializer
    import serializer_pkg::*;
#(
    parameter int W     = SER_W,
    parameter int MOD_W = $clog2(W)
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic [W-1:0]     data_i,
    input  logic [MOD_W-1:0] data_mod_i,
    input  logic             data_val_i,
    output logic             ser_data_o,
    output logic             ser_data_val_o,
    output logic             busy_o
);

    // One extra counter bit so a full-width length of W does not wrap to 0.
    localparam int              CW       = MOD_W + 1;
    localparam logic [CW-1:0]   FULL_LEN = CW'(W);
    localparam logic [CW-1:0]   ONE      = CW'(1);

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    shreg;     // holds the not-yet-sent bits, next bit at [W-1]
    logic [CW-1:0]   cnt;       // bits remaining, including the one on ser_data_o
    logic            len_ok;
    logic [CW-1:0]   eff_len;
    logic            accept;
    logic            advance;
    logic            ser_nxt;
    logic            val_nxt;
    logic            busy_nxt;

    always_comb begin
        len_ok  = (data_mod_i != MOD_W'(1)) && (data_mod_i != MOD_W'(2));
        eff_len = (data_mod_i == '0) ? FULL_LEN : {1'b0, data_mod_i};
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (data_val_i && len_ok) state_nxt = SEND;
            SEND: if (cnt <= ONE)           state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        accept   = (state == IDLE) && data_val_i && len_ok;
        advance  = (state == SEND) && (cnt > ONE);
        ser_nxt  = 1'b0;
        val_nxt  = 1'b0;
        busy_nxt = (state_nxt == SEND);
        if (accept) begin
            // First bit goes straight from the input so it appears one cycle after acceptance.
            ser_nxt = data_i[W-1];
            val_nxt = 1'b1;
        end else if (advance) begin
            ser_nxt = shreg[W-1];
            val_nxt = 1'b1;
        end
    end

    // Shift register, down-counter and output registers
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            shreg          <= '0;
            cnt            <= '0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            if (accept) begin
                shreg <= data_i << 1;
                cnt   <= eff_len;
            end else if (advance) begin
                shreg <= shreg << 1;
                cnt   <= cnt - ONE;
            end else if (state == SEND) begin
                cnt   <= '0;
            end
            ser_data_o     <= ser_nxt;
            ser_data_val_o <= val_nxt;
            busy_o         <= busy_nxt;
        end
    end

endmodule : serializer

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter W, default 16, output word width in bits; legal values are powers of two, 4 or greater.
REQ-002 Parameter MOD_W, default $clog2(W), width of the length field.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 srst_n_i  input  1  reset, synchronous, active-low.
REQ-005 data_i  input  W  parallel word to transmit; bit W-1 is sent first.
REQ-006 data_mod_i  input  MOD_W  number of valid bits; counted from bit W-1 downward.
REQ-007 data_val_i  input  1  request strobe; data_i and data_mod_i are qualified by it.
REQ-008 ser_data_o  output  1  serial data bit.
REQ-009 ser_data_val_o  output  1  ser_data_o is valid this cycle.
REQ-010 busy_o  output  1  transmission in progress; requests are ignored while it is high.

Function
REQ-011 The FSM SHALL have two states: IDLE and SEND.
REQ-012 In IDLE, data_val_i=1 with a legal length SHALL latch data_i and the effective length, then move to SEND at the same edge.
REQ-013 Effective length SHALL be W when data_mod_i=0, and data_mod_i otherwise.
REQ-014 data_mod_i of 1 or 2 SHALL be an illegal length: the request is dropped, the FSM stays in IDLE, and no output activity occurs.
REQ-015 The first bit (data_i[W-1]) SHALL appear on ser_data_o with ser_data_val_o=1 in the cycle immediately after the accepting edge; latency is 1 cycle.
REQ-016 In SEND, one bit SHALL be emitted per cycle, MSB first, with no gaps; the last bit is data_i[W-L] for length L.
REQ-017 After L valid cycles, the FSM SHALL return to IDLE at the edge following the last bit.
REQ-018 busy_o SHALL equal (state==SEND); it is high exactly during the L cycles in which ser_data_val_o is high.
REQ-019 data_val_i asserted while busy_o=1 SHALL be ignored; latched data and length stay unchanged.
REQ-020 Changes on data_i and data_mod_i after acceptance SHALL NOT affect the word in flight.
REQ-021 Back-to-back requests: a request presented in the first cycle with busy_o=0 SHALL be accepted, giving a minimum gap of 1 idle cycle between words.
REQ-022 When ser_data_val_o=0, ser_data_o SHALL be driven to 0.
REQ-023 The bit counter SHALL be MOD_W+1 bits wide so that a length of W is representable without wrap.
REQ-024 ser_data_o, ser_data_val_o and busy_o SHALL be registered outputs.

Reset
REQ-025 srst_n_i=0 at an edge SHALL force the IDLE state, ser_data_o=0, ser_data_val_o=0, busy_o=0 and clear the counter, from the next cycle on.
REQ-026 Reset during SEND SHALL abort the word; no further bits of that word are emitted after reset is released.
REQ-027 data_val_i sampled in the same edge as srst_n_i=0 SHALL be discarded.

Structure
REQ-028 Package serializer_pkg SHALL hold the state enum (IDLE, SEND) and the default W/MOD_W constants; the deserializer shares the width constant.
REQ-029 There SHALL be no sub-module: one FSM, one shift register and one down-counter in a single module.

Verification
REQ-030 Request data_i=16'hA5F0, mod=0: the next 16 cycles SHALL carry 1010_0101_1111_0000 with valid and busy high, then both drop.
REQ-031 Request data_i=16'hC000, mod=3: the stream SHALL be 1,1,0 over 3 cycles, then IDLE.
REQ-032 Request with mod=1 and mod=2: ser_data_val_o and busy_o SHALL stay 0 for 20 cycles.
REQ-033 Request 16'hFFFF, then data_val_i=1 with 16'h0000 during cycles 2..10 of the word: the stream SHALL be all 1s with exactly 16 bits.
REQ-034 srst_n_i=0 for one cycle at bit 5 of 16'h1234: the outputs SHALL be 0 from the next cycle; a new request for 16'h8001 then serializes correctly.
REQ-035 Loopback into the deserializer with 50 random mod=0 words and random gaps: every word SHALL be received intact.
